datapath_mc: RTL and testbench
==============================

DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath and register width.
REQ-002 SHALL have parameter REGBITS, default 4, register address bits; the register file depth is 2**REGBITS.
REQ-003 SHALL have parameter IMMBITS, default 8, immediate field width, taken from instr[IMMBITS-1:0].
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-005 SHALL have ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- instr  in  WIDTH  instruction; rdst=instr[11:8], rsrc=instr[3:0], imm=instr[IMMBITS-1:0]
- ctrl  in  11  control word: [3:0] alucode, [4] a_one, [5] imm_sel, [6] b_pc, [7] load, [8] pc_wr, [9] reg_wr, [10] store
- in_valid  in  1  instr/ctrl valid
- in_ready  out  1  block can accept an instruction
- mem_req  out  1  data-memory request
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  store data
- mem_rdata  in  WIDTH  load data, valid with mem_ack
- mem_ack  in  1  memory completion
- pc_out  out  WIDTH  program counter
- psr  out  5  flags {N,Z,F,L,C}
- busy  out  1  instruction in flight

Function
REQ-006 SHALL run an FSM with states IDLE, EXEC, MEM, WB; in_ready=1 only in IDLE; busy=!in_ready.
REQ-007 SHALL latch instr and ctrl and go to EXEC on in_valid && in_ready; in_valid outside IDLE is ignored.
REQ-008 EXEC SHALL compute the ALU operands: A = a_one ? 1 : (imm_sel ? sign-extended imm : R[rdst]); B = b_pc ? PC : R[rsrc].
REQ-009 EXEC SHALL register the ALU result and, unless alucode is MOV, update psr.
REQ-010 From EXEC, the FSM SHALL go to MEM if load or store is set, otherwise to WB.
REQ-011 The ALU SHALL implement these alucodes: 0 ADD, 1 SUB (B-A), 2 AND, 3 OR, 4 XOR, 5 MOV (A), 6 CMP (B-A, flags only, result discarded), 7 LSH (B<<A[3:0]); codes 8-15 give result 0 and leave flags unchanged.
REQ-012 Flags SHALL be: C = carry-out of ADD or borrow of SUB/CMP; F = signed overflow; L = B<A unsigned; Z = result==0; N = result MSB. Arithmetic wraps modulo 2**WIDTH.
REQ-013 In MEM, mem_req SHALL be held high with mem_addr = ALU result, mem_we = store, and mem_wdata = R[rdst], until a cycle with mem_ack=1; the FSM then goes to WB.
REQ-014 On a load, the block SHALL capture mem_rdata in the mem_ack cycle.
REQ-015 mem_ack in the first MEM cycle SHALL be accepted; mem_ack outside MEM is ignored.
REQ-016 In WB, if reg_wr is set, R[rdst] SHALL be written with the load data when load is set, otherwise with the ALU result.
REQ-017 In WB, PC SHALL become the ALU result if pc_wr is set, otherwise PC+1, wrapping at 2**WIDTH; the FSM then returns to IDLE.
REQ-018 In WB, reg_wr and pc_wr both set SHALL perform both updates; CMP with reg_wr writes nothing.
REQ-019 Latency SHALL be 3 cycles from accept to in_ready for non-memory instructions, and 3 + (cycles waiting for ack) for memory instructions.
REQ-020 Register reads SHALL see the value written by the previous instruction's WB.

Reset
REQ-021 Reset SHALL force the FSM to IDLE, PC=0, psr=0, mem_req=0, mem_we=0, in_ready=1, and busy=0 on the next clock edge.
REQ-022 Reset during MEM SHALL drop mem_req the next cycle; the pending register or PC write is discarded.
REQ-023 Register file contents SHALL be unaffected by reset.

Structure
REQ-024 A shared package SHALL hold the alucode constants, the ctrl bit-index constants, the state encoding, and the flag bit positions.
REQ-025 The register file SHALL be a separate sub-module regfile_p (parameters WIDTH and REGBITS, two async read ports, one sync write port); the ALU stays combinational inside datapath_mc.

Verification
REQ-026 Reset, then ADD with imm_sel, imm=0xFF, R[rsrc]=5, reg_wr -> R[rdst]=0x0004, C=1, PC=1, in_ready back after 3 cycles.
REQ-027 CMP with A=3, B=3 -> Z=1, C=0, L=0, no register changes, PC+1.
REQ-028 Load with mem_ack delayed 4 cycles -> mem_req high 5 cycles with a stable address; R[rdst]=mem_rdata; PC+1.
REQ-029 Store with ack in the first MEM cycle -> one-cycle mem_req with mem_we=1 and mem_wdata=R[rdst].
REQ-030 pc_wr with ALU result 0xFFFF, then a non-jump instruction -> PC=0xFFFF, then PC=0x0000.
REQ-031 Reset asserted mid-MEM -> mem_req=0 next cycle, PC=0, no register write; in_valid held during busy -> no second accept.

Source files
------------

// File: rtl/datapath_mc_pkg.sv
// Shared definitions for the multicycle datapath: FSM states, ALU codes,
// control-word bit positions and status-flag bit positions.
package datapath_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_MOV = 4'd5;
  localparam logic [3:0] ALU_CMP = 4'd6;
  localparam logic [3:0] ALU_LSH = 4'd7;

  localparam int unsigned CTRL_W       = 11;
  localparam int unsigned CTRL_A_ONE   = 4;
  localparam int unsigned CTRL_IMM_SEL = 5;
  localparam int unsigned CTRL_B_PC    = 6;
  localparam int unsigned CTRL_LOAD    = 7;
  localparam int unsigned CTRL_PC_WR   = 8;
  localparam int unsigned CTRL_REG_WR  = 9;
  localparam int unsigned CTRL_STORE   = 10;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

endpackage

// File: rtl/datapath_mc_regfile_p.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Contents are deliberately not reset.
module regfile_p
  import datapath_mc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clock,
  input  logic               we,
  input  logic [REGBITS-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [REGBITS-1:0] raddr_a,
  input  logic [REGBITS-1:0] raddr_b,
  output logic [WIDTH-1:0]   rdata_a,
  output logic [WIDTH-1:0]   rdata_b
);

  logic [WIDTH-1:0] regs_q [2**REGBITS];

  // Write port
  always_ff @(posedge clock) begin
    if (we) regs_q[waddr] <= wdata;
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/datapath_mc.sv
// Multicycle datapath: IDLE -> EXEC -> [MEM] -> WB, combinational ALU,
// registered result/flags, data-memory handshake and program counter.
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int IMMBITS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  instr,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [WIDTH-1:0]  pc_out,
  output logic [4:0]        psr,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    instr_q, instr_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    alu_q, alu_d;
  logic [WIDTH-1:0]    ld_q, ld_d;
  logic [WIDTH-1:0]    pc_q, pc_d;
  logic [4:0]          psr_q, psr_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  logic [REGBITS-1:0]  rdst, rsrc;
  logic [IMMBITS-1:0]  imm;
  logic [WIDTH-1:0]    imm_ext, r_dst, r_src;
  logic [3:0]          alucode;
  logic [WIDTH-1:0]    a_op, b_op, alu_res;
  logic [WIDTH:0]      sum, diff;
  logic                carry, ovf, flags_upd;
  logic [4:0]          flags_new;
  logic                rf_we;
  logic [WIDTH-1:0]    rf_wd;
  logic                unused_instr;

  assign rdst    = instr_q[8 +: REGBITS];
  assign rsrc    = instr_q[0 +: REGBITS];
  assign imm     = instr_q[IMMBITS-1:0];
  assign imm_ext = {{(WIDTH-IMMBITS){imm[IMMBITS-1]}}, imm};
  assign alucode = ctrl_q[3:0];
  assign unused_instr = ^instr_q;

  regfile_p #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS)
  ) u_regfile (
    .clock   (clock),
    .we      (rf_we),
    .waddr   (rdst),
    .wdata   (rf_wd),
    .raddr_a (rdst),
    .raddr_b (rsrc),
    .rdata_a (r_dst),
    .rdata_b (r_src)
  );

  // ALU: operand selection, result and candidate flags
  always_comb begin
    a_op = ctrl_q[CTRL_A_ONE] ? WIDTH'(1) : (ctrl_q[CTRL_IMM_SEL] ? imm_ext : r_dst);
    b_op = ctrl_q[CTRL_B_PC] ? pc_q : r_src;
    sum  = {1'b0, a_op} + {1'b0, b_op};
    diff = {1'b0, b_op} - {1'b0, a_op};
    alu_res   = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    flags_upd = 1'b1;
    case (alucode)
      ALU_ADD: begin
        alu_res = sum[WIDTH-1:0];
        carry   = sum[WIDTH];
        ovf     = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);
      end
      ALU_SUB, ALU_CMP: begin
        alu_res = diff[WIDTH-1:0];
        carry   = diff[WIDTH];
        ovf     = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (diff[WIDTH-1] != b_op[WIDTH-1]);
      end
      ALU_AND: alu_res = a_op & b_op;
      ALU_OR:  alu_res = a_op | b_op;
      ALU_XOR: alu_res = a_op ^ b_op;
      ALU_MOV: begin
        alu_res   = a_op;
        flags_upd = 1'b0;
      end
      ALU_LSH: alu_res = b_op << a_op[3:0];
      default: flags_upd = 1'b0;
    endcase
    flags_new         = '0;
    flags_new[FLAG_N] = alu_res[WIDTH-1];
    flags_new[FLAG_Z] = (alu_res == '0);
    flags_new[FLAG_F] = ovf;
    flags_new[FLAG_L] = (b_op < a_op);
    flags_new[FLAG_C] = carry;
  end

  // Next-state and register-file write control
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    ctrl_d      = ctrl_q;
    alu_d       = alu_q;
    ld_d        = ld_q;
    pc_d        = pc_q;
    psr_d       = psr_q;
    in_ready_d  = in_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_we       = 1'b0;
    rf_wd       = ctrl_q[CTRL_LOAD] ? ld_q : alu_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          instr_d    = instr;
          ctrl_d     = ctrl;
          in_ready_d = 1'b0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_d = alu_res;
        if (flags_upd) psr_d = flags_new;
        if (ctrl_q[CTRL_LOAD] || ctrl_q[CTRL_STORE]) begin
          mem_req_d   = 1'b1;
          mem_we_d    = ctrl_q[CTRL_STORE];
          mem_addr_d  = alu_res;
          mem_wdata_d = r_dst;
          state_d     = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          ld_d      = mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_WB;
        end
      end
      ST_WB: begin
        // Reset in this cycle must also suppress the write, not just the state update
        rf_we      = ctrl_q[CTRL_REG_WR] && (alucode != ALU_CMP) && !reset;
        pc_d       = ctrl_q[CTRL_PC_WR] ? alu_q : pc_q + WIDTH'(1);
        in_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers; reset clears control state only
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      psr_q      <= '0;
      in_ready_q <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      psr_q      <= psr_d;
      in_ready_q <= in_ready_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
    end
    instr_q     <= instr_d;
    ctrl_q      <= ctrl_d;
    alu_q       <= alu_d;
    ld_q        <= ld_d;
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
  end

  assign in_ready  = in_ready_q;
  assign busy      = ~in_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_out    = pc_q;
  assign psr       = psr_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Randomized self-checking bench for datapath_mc against an arithmetic
// reference model of registers, PC and flags.
module tb_datapath_mc;

  logic        clock;
  logic        reset;
  logic [15:0] instr;
  logic [10:0] ctrl;
  logic        in_valid;
  logic        in_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] pc_out;
  logic [4:0]  psr;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_reg [16];
  logic [15:0] m_pc;
  logic [4:0]  m_psr;

  datapath_mc #(
    .WIDTH   (16),
    .REGBITS (4),
    .IMMBITS (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .instr     (instr),
    .ctrl      (ctrl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc_out    (pc_out),
    .psr       (psr),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [10:0] mk_ctrl(input int op, input bit a_one, input bit imm_sel,
                                          input bit b_pc, input bit load, input bit pc_wr,
                                          input bit reg_wr, input bit store);
    logic [3:0] o;
    o = 4'(op);
    return {store, reg_wr, pc_wr, load, b_pc, imm_sel, a_one, o};
  endfunction

  // Reference ALU written with plain integer arithmetic
  task automatic model_alu(input int op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic [4:0] flg, output bit upd);
    longint ua, ub, sa, sb, full, sfull;
    bit c, f;
    ua = longint'(a); ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    c = 0; f = 0; upd = 1; full = 0;
    case (op)
      0: begin
        full = ua + ub; sfull = sa + sb;
        c = (full > 65535); f = (sfull > 32767) || (sfull < -32768);
      end
      1, 6: begin
        full = ub - ua; sfull = sb - sa;
        c = (ub < ua); f = (sfull > 32767) || (sfull < -32768);
      end
      2: full = longint'(a & b);
      3: full = longint'(a | b);
      4: full = longint'(a ^ b);
      5: begin full = ua; upd = 0; end
      7: full = ub * (longint'(1) << (ua % 16));
      default: begin full = 0; upd = 0; end
    endcase
    full = ((full % 65536) + 65536) % 65536;
    res = 16'(full);
    flg = {full >= 32768, full == 0, f, ub < ua, c};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pc  = 16'h0;
    m_psr = 5'h0;
  endtask

  // Issue one instruction, serve memory, then check against the model
  task automatic do_instr(input logic [15:0] ins, input logic [10:0] ct, input int delay,
                          input logic [15:0] rdata, input bit hold,
                          output int lat, output int reqs);
    int op, rd, rs, iv;
    logic [15:0] a, b, res, wd;
    logic [4:0] flg;
    bit upd, memop;
    op = int'(ct[3:0]); rd = int'(ins[11:8]); rs = int'(ins[3:0]);
    iv = int'(ins[7:0]);
    if (iv > 127) iv -= 256;
    a = ct[4] ? 16'd1 : (ct[5] ? 16'(iv) : m_reg[rd]);
    b = ct[6] ? m_pc : m_reg[rs];
    model_alu(op, a, b, res, flg, upd);
    wd = m_reg[rd];
    memop = ct[7] | ct[10];

    check("ready_before", {31'b0, in_ready}, 32'd1);
    instr = ins; ctrl = ct; in_valid = 1'b1;
    tick();
    in_valid = hold;
    instr = 16'($urandom);
    ctrl  = 11'($urandom);
    check("busy_exec", {31'b0, busy}, 32'd1);
    lat = 1; reqs = 0;
    while (!in_ready && lat < 64) begin
      if (mem_req) begin
        reqs++;
        check("mem_addr", {16'b0, mem_addr}, {16'b0, res});
        check("mem_we", {31'b0, mem_we}, {31'b0, ct[10]});
        if (ct[10]) check("mem_wdata", {16'b0, mem_wdata}, {16'b0, wd});
        mem_ack   = (reqs > delay);
        mem_rdata = (reqs > delay) ? rdata : 16'($urandom);
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    check("no_timeout", {31'b0, lat < 64}, 32'd1);

    if (upd) m_psr = flg;
    if (ct[9] && op != 6) m_reg[rd] = ct[7] ? rdata : res;
    m_pc = ct[8] ? res : m_pc + 16'd1;

    check("mem_cycles", reqs, memop ? delay + 1 : 0);
    check("latency", lat, 3 + (memop ? delay + 1 : 0));
    check("pc", {16'b0, pc_out}, {16'b0, m_pc});
    check("psr", {27'b0, psr}, {27'b0, m_psr});
    check("busy_idle", {31'b0, busy}, 32'd0);
    check("mem_req_idle", {31'b0, mem_req}, 32'd0);
  endtask

  initial begin
    int lat, reqs, n, op;
    logic [15:0] ins, pc_before;
    logic [10:0] ct;
    bit ld, st;

    reset = 1'b1; in_valid = 1'b0; instr = '0; ctrl = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
    tick();
    do_reset();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_pc", {16'b0, pc_out}, 32'd0);
    check("rst_psr", {27'b0, psr}, 32'd0);

    // R15 = 5 via load, then reset (registers survive) and ADD imm 0xFF
    do_instr(16'h0F00, mk_ctrl(5, 0, 1, 0, 1, 0, 1, 0), 1, 16'h0005, 0, lat, reqs);
    do_reset();
    do_instr(16'h03FF, mk_ctrl(0, 0, 1, 0, 0, 0, 1, 0), 0, 16'h0, 0, lat, reqs);
    check("add_lat", lat, 3);
    check("add_pc", {16'b0, pc_out}, 32'd1);
    check("add_carry", {31'b0, psr[0]}, 32'd1);
    check("add_r3", {16'b0, m_reg[3]}, 32'h0004);

    // Fill every register with random data through loads
    for (int r = 0; r < 16; r++)
      do_instr({4'h0, 4'(r), 8'($urandom)}, mk_ctrl(5, 0, 1, 0, 1, 0, 1, 0),
               $urandom_range(0, 2), 16'($urandom), 0, lat, reqs);

    // CMP 3 vs 3
    do_instr(16'h0300, mk_ctrl(5, 0, 1, 0, 1, 0, 1, 0), 0, 16'h0003, 0, lat, reqs);
    pc_before = pc_out;
    do_instr(16'h0503, mk_ctrl(6, 0, 1, 0, 0, 0, 1, 0), 0, 16'h0, 0, lat, reqs);
    check("cmp_z", {31'b0, psr[3]}, 32'd1);
    check("cmp_c", {31'b0, psr[0]}, 32'd0);
    check("cmp_l", {31'b0, psr[1]}, 32'd0);
    check("cmp_pc", {16'b0, pc_out}, {16'b0, pc_before + 16'd1});

    // Load with 4 wait cycles, store with immediate ack
    do_instr(16'h0740, mk_ctrl(5, 0, 1, 0, 1, 0, 1, 0), 4, 16'hBEEF, 0, lat, reqs);
    check("ld_req_cycles", reqs, 5);
    check("ld_r7", {16'b0, m_reg[7]}, 32'hBEEF);
    do_instr(16'h0720, mk_ctrl(5, 0, 1, 0, 0, 0, 0, 1), 0, 16'h0, 0, lat, reqs);
    check("st_req_cycles", reqs, 1);

    // Jump to 0xFFFF, then PC wraps
    do_instr(16'h00FF, mk_ctrl(5, 0, 1, 0, 0, 1, 0, 0), 0, 16'h0, 0, lat, reqs);
    check("jmp_pc", {16'b0, pc_out}, 32'hFFFF);
    do_instr(16'h0001, mk_ctrl(5, 0, 1, 0, 0, 0, 0, 0), 0, 16'h0, 0, lat, reqs);
    check("wrap_pc", {16'b0, pc_out}, 32'h0000);

    // Reset while a load waits in MEM: no write, PC back to 0
    instr = 16'h0A12; ctrl = mk_ctrl(5, 0, 1, 0, 1, 1, 1, 0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    check("mid_mem_req", {31'b0, mem_req}, 32'd1);
    tick();
    check("mid_mem_req2", {31'b0, mem_req}, 32'd1);
    do_reset();
    check("mid_rst_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_pc", {16'b0, pc_out}, 32'd0);
    check("mid_rst_psr", {27'b0, psr}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);

    // in_valid held high through the whole busy period
    do_instr(16'h0B05, mk_ctrl(0, 0, 1, 0, 0, 0, 1, 0), 0, 16'h0, 1, lat, reqs);
    check("hold_lat", lat, 3);

    // Randomized instruction stream
    for (int k = 0; k < 250; k++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      n  = int'($urandom_range(0, 3));
      ld = (n == 1) && (op != 6);
      st = (n == 2) && (op != 6);
      ct = mk_ctrl(op, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3) == 0, ld,
                   ($urandom_range(0, 5) == 0) && (op != 6),
                   $urandom_range(0, 9) < 7, st);
      ins = 16'($urandom);
      do_instr(ins, ct, $urandom_range(0, 3), 16'($urandom),
               $urandom_range(0, 9) == 0, lat, reqs);
    end

    // Read every register back through stores
    for (int r = 0; r < 16; r++)
      do_instr({4'h0, 4'(r), 8'h00}, mk_ctrl(5, 1, 0, 0, 0, 0, 0, 1), 0, 16'h0, 0, lat, reqs);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
